// File: rtl/bcd_countdown.sv
// ---------------------------------------------------------------------------
// bcd_countdown
//   MM:SS countdown timer with keypad digit entry.
//   Digits are shifted in from the right while idle; start begins counting
//   down once per second (TICK_DIV clk cycles); stop pauses, and a second
//   stop (or stop while idle) clears the display. Reaching 00:00 produces
//   a one-cycle done pulse, then the block returns to idle.
//
// Ports
//   clk          sole clock, rising edge
//   clear        synchronous active-low reset
//   digit_in     BCD digit from keypad encoder
//   digit_valid  single-cycle strobe qualifying digit_in
//   start        start/resume request (level)
//   stop         pause/cancel request (level)
//   min_tens, min_units, sec_tens, sec_units   registered BCD display MM:SS
//   running      high while counting
//   done         one-cycle pulse on completion
// ---------------------------------------------------------------------------
module bcd_countdown #(
   parameter int unsigned TICK_DIV = 100
) (
   input  logic       clk,
   input  logic       clear,
   input  logic [3:0] digit_in,
   input  logic       digit_valid,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] min_tens,
   output logic [3:0] min_units,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_units,
   output logic       running,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

   state_t      state, state_nx;
   logic [15:0] presc, presc_nx;
   logic [3:0]  mt_nx, mu_nx, st_nx, su_nx;

   // One-second decrement of the current display value
   logic [3:0]  dec_mt, dec_mu, dec_st, dec_su;
   logic        borrow_su, borrow_st, borrow_mu;
   logic        dec_zero;
   logic        tick;
   logic        digits_zero;
   logic        digit_ok;

   always_comb begin
      borrow_su = (sec_units == 4'd0);
      borrow_st = borrow_su && (sec_tens == 4'd0);
      borrow_mu = borrow_st && (min_units == 4'd0);

      dec_su = borrow_su ? 4'd9 : sec_units - 4'd1;
      // Seconds tens wraps to 5 so 1:00 becomes 0:59; entered 6..9 just count down
      dec_st = borrow_su ? ((sec_tens == 4'd0) ? 4'd5 : sec_tens - 4'd1) : sec_tens;
      dec_mu = borrow_st ? ((min_units == 4'd0) ? 4'd9 : min_units - 4'd1) : min_units;
      dec_mt = borrow_mu ? min_tens - 4'd1 : min_tens;

      dec_zero = (dec_mt == 4'd0) && (dec_mu == 4'd0) &&
                 (dec_st == 4'd0) && (dec_su == 4'd0);
   end

   assign tick        = (presc == PRESC_LAST);
   assign digits_zero = (min_tens == 4'd0) && (min_units == 4'd0) &&
                        (sec_tens == 4'd0) && (sec_units == 4'd0);
   assign digit_ok    = digit_valid && (digit_in <= 4'd9);

   // Next-state / next-datapath logic; priority stop > start > digit/tick
   always_comb begin
      state_nx = state;
      presc_nx = presc;
      mt_nx    = min_tens;
      mu_nx    = min_units;
      st_nx    = sec_tens;
      su_nx    = sec_units;

      unique case (state)
         IDLE: begin
            if (stop) begin
               mt_nx = 4'd0;
               mu_nx = 4'd0;
               st_nx = 4'd0;
               su_nx = 4'd0;
            end else if (start) begin
               if (!digits_zero) begin
                  state_nx = RUN;
                  presc_nx = '0;
               end
            end else if (digit_ok) begin
               mt_nx = min_units;
               mu_nx = sec_tens;
               st_nx = sec_units;
               su_nx = digit_in;
            end
         end

         RUN: begin
            if (stop) begin
               // Pause drops a coincident tick; prescaler is held as-is
               state_nx = PAUSE;
            end else if (tick) begin
               presc_nx = '0;
               mt_nx    = dec_mt;
               mu_nx    = dec_mu;
               st_nx    = dec_st;
               su_nx    = dec_su;
               if (dec_zero) begin
                  state_nx = DONE;
               end
            end else begin
               presc_nx = presc + 16'd1;
            end
         end

         PAUSE: begin
            if (stop) begin
               state_nx = IDLE;
               mt_nx    = 4'd0;
               mu_nx    = 4'd0;
               st_nx    = 4'd0;
               su_nx    = 4'd0;
            end else if (start) begin
               state_nx = RUN;
            end
         end

         DONE: begin
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clear) begin
         state     <= IDLE;
         presc     <= '0;
         min_tens  <= '0;
         min_units <= '0;
         sec_tens  <= '0;
         sec_units <= '0;
         running   <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         presc     <= presc_nx;
         min_tens  <= mt_nx;
         min_units <= mu_nx;
         sec_tens  <= st_nx;
         sec_units <= su_nx;
         // Status flags are registered copies of the next state
         running   <= (state_nx == RUN);
         done      <= (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_bcd_countdown.sv
// ---------------------------------------------------------------------------
// tb_bcd_countdown
//   Self-checking bench for bcd_countdown with TICK_DIV=4. A driver applies
//   one set of inputs per cycle, advances a reference model (time held as
//   plain minutes/seconds numbers) and queues the expected outputs; a monitor
//   pops one expectation after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_bcd_countdown;

   localparam int TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] digit_in = 4'd0;
   logic       digit_valid = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [3:0] min_tens, min_units, sec_tens, sec_units;
   logic       running, done;

   bcd_countdown #(.TICK_DIV(TICK_DIV)) dut (
      .clk        (clk),
      .clear      (clear),
      .digit_in   (digit_in),
      .digit_valid(digit_valid),
      .start      (start),
      .stop       (stop),
      .min_tens   (min_tens),
      .min_units  (min_units),
      .sec_tens   (sec_tens),
      .sec_units  (sec_units),
      .running    (running),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [17:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: 4-digit value as a decimal number, mode, elapsed cycles
   int m_num   = 0;   // MMSS as 0..9999
   int m_mode  = 0;   // 0 idle, 1 counting, 2 paused, 3 finished
   int m_phase = 0;   // cycles since last second boundary while counting

   function automatic logic [17:0] expected_out();
      logic [3:0] d3, d2, d1, d0;
      d3 = 4'(m_num / 1000);
      d2 = 4'((m_num / 100) % 10);
      d1 = 4'((m_num / 10) % 10);
      d0 = 4'(m_num % 10);
      return {d3, d2, d1, d0, (m_mode == 1), (m_mode == 3)};
   endfunction

   task automatic model_step(input bit clr, input bit st, input bit sp,
                             input bit dv, input int d);
      int mins, secs;
      if (!clr) begin
         m_num = 0; m_mode = 0; m_phase = 0;
         return;
      end
      case (m_mode)
         0: begin
            if (sp) m_num = 0;
            else if (st) begin
               if (m_num != 0) begin m_mode = 1; m_phase = 0; end
            end else if (dv && d <= 9) m_num = (m_num * 10 + d) % 10000;
         end
         1: begin
            if (sp) m_mode = 2;
            else begin
               m_phase++;
               if (m_phase == TICK_DIV) begin
                  m_phase = 0;
                  mins = m_num / 100;
                  secs = m_num % 100;
                  if (secs > 0) secs--;
                  else begin secs = 59; mins--; end
                  m_num = mins * 100 + secs;
                  if (m_num == 0) m_mode = 3;
               end
            end
         end
         2: begin
            if (sp) begin m_num = 0; m_mode = 0; end
            else if (st) m_mode = 1;
         end
         default: m_mode = 0;
      endcase
   endtask

   task automatic cyc(input bit clr, input bit st, input bit sp,
                      input bit dv, input logic [3:0] d, input string nm);
      exp_t e;
      @(negedge clk);
      clear = clr; start = st; stop = sp; digit_valid = dv; digit_in = d;
      model_step(clr, st, sp, dv, int'(d));
      e.val  = expected_out();
      e.name = nm;
      q.push_back(e);
   endtask

   task automatic idle(input int n, input string nm);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 4'd0, nm);
   endtask

   task automatic load4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d, input string nm);
      cyc(1, 0, 0, 1, a, nm);
      cyc(1, 0, 0, 1, b, nm);
      cyc(1, 0, 0, 1, c, nm);
      cyc(1, 0, 0, 1, d, nm);
   endtask

   task automatic cancel(input string nm);
      cyc(1, 0, 1, 0, 4'd0, nm);
      cyc(1, 0, 1, 0, 4'd0, nm);
   endtask

   // Monitor: one expectation per rising edge once the driver has started
   initial begin
      exp_t        e;
      logic [17:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e   = q.pop_front();
            got = {min_tens, min_units, sec_tens, sec_units, running, done};
            checks++;
            if (got !== e.val) begin
               errors++;
               $display("FAIL %s t=%0t got=%h_%b%b want=%h_%b%b", e.name, $time,
                        got[17:2], got[1], got[0], e.val[17:2], e.val[1], e.val[0]);
            end
         end
      end
   end

   initial begin
      bit st, sp, dv, clr;
      logic [3:0] d;

      // reset
      cyc(0, 0, 0, 0, 4'd0, "reset");
      cyc(0, 1, 1, 1, 4'd3, "reset");
      idle(2, "post_reset");

      // entry 01:05, run, digit during RUN ignored
      load4(4'd0, 4'd1, 4'd0, 4'd5, "load0105");
      cyc(1, 1, 0, 0, 4'd0, "start0105");
      idle(4, "tick0104");
      cyc(1, 0, 0, 1, 4'd7, "dv_in_run");
      idle(3, "run0105");
      cancel("cancel0105");

      // borrow chains
      load4(4'd0, 4'd1, 4'd0, 4'd0, "load0100");
      cyc(1, 1, 0, 0, 4'd0, "start0100");
      idle(5, "tick0059");
      cancel("cancel0100");
      load4(4'd1, 4'd0, 4'd0, 4'd0, "load1000");
      cyc(1, 1, 0, 0, 4'd0, "start1000");
      idle(5, "tick0959");
      cancel("cancel1000");
      load4(4'd9, 4'd9, 4'd9, 4'd9, "load9999");
      cyc(1, 1, 0, 0, 4'd0, "start9999");
      idle(5, "tick9998");
      cancel("cancel9999");
      load4(4'd9, 4'd9, 4'd0, 4'd0, "load9900");
      cyc(1, 1, 0, 0, 4'd0, "start9900");
      idle(5, "tick9859");
      cancel("cancel9900");

      // completion from 00:02
      load4(4'd0, 4'd0, 4'd0, 4'd2, "load0002");
      cyc(1, 1, 0, 0, 4'd0, "start0002");
      idle(10, "done0002");
      cyc(1, 1, 1, 1, 4'd4, "after_done");
      idle(2, "after_done");

      // pause / resume / cancel
      load4(4'd0, 4'd0, 4'd1, 4'd0, "load0010");
      cyc(1, 1, 0, 0, 4'd0, "start0010");
      idle(2, "run0010");
      cyc(1, 0, 1, 0, 4'd0, "pause0010");
      idle(20, "hold0010");
      cyc(1, 1, 0, 0, 4'd0, "resume0010");
      idle(3, "tick0009");
      cancel("cancel0010");

      // boundary cases
      cyc(0, 0, 0, 0, 4'd0, "clear_idle");
      cyc(1, 1, 0, 0, 4'd0, "start_zero");
      idle(2, "start_zero");
      cyc(1, 0, 0, 1, 4'hA, "digit_0xA");
      load4(4'd0, 4'd0, 4'd0, 4'd5, "load0005");
      cyc(1, 1, 1, 0, 4'd0, "start_stop");
      idle(2, "start_stop");

      // clear mid-RUN with start and digit_valid asserted
      load4(4'd0, 4'd0, 4'd3, 4'd0, "load0030");
      cyc(1, 1, 0, 0, 4'd0, "start0030");
      idle(3, "run0030");
      cyc(0, 1, 0, 1, 4'd6, "clear_run");
      cyc(0, 1, 0, 1, 4'd6, "clear_run");
      idle(4, "after_clear");

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         clr = ($urandom_range(0, 199) != 0);
         st  = ($urandom_range(0, 7) == 0);
         sp  = ($urandom_range(0, 39) == 0);
         dv  = ($urandom_range(0, 2) == 0);
         d   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15))
                                           : 4'($urandom_range(0, 9));
         cyc(clr, st, sp, dv, d, "random");
      end

      idle(1, "tail");
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 Parameter TICK_DIV, default 100, meaning clk cycles per 1 s countdown tick (100 Hz clk); legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 clear  input  1  reset, synchronous and active-low: sampled only on the rising edge of clk; clear==0 resets the block.
REQ-004 digit_in  input  4  BCD digit from the keypad encoder.
REQ-005 digit_valid  input  1  single-cycle strobe qualifying digit_in.
REQ-006 start  input  1  start/resume request, level-sampled per cycle.
REQ-007 stop  input  1  pause/cancel request, level-sampled per cycle.
REQ-008 min_tens, min_units, sec_tens, sec_units  output  4 each  registered BCD time value MM:SS.
REQ-009 running  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse on countdown completion.

Function
REQ-011 FSM states: IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-012 Digit entry: IDLE only; on digit_valid with digit_in<=9 and start==0 and stop==0, shift left: min_tens<-min_units, min_units<-sec_tens, sec_tens<-sec_units, sec_units<-digit_in.
REQ-013 digit_in>9, or digit_valid outside IDLE, ignored; no register change.
REQ-014 Priority every cycle: clear > stop > start > digit_valid/tick.
REQ-015 IDLE+start: if all four digits 0 -> stay IDLE; else -> RUN, prescaler set to 0.
REQ-016 IDLE+stop: all digits -> 0, stay IDLE.
REQ-017 Prescaler: counts 0..TICK_DIV-1 only in RUN; tick when count==TICK_DIV-1, count wraps to 0 same edge; first tick TICK_DIV cycles after entering RUN from IDLE.
REQ-018 Decrement per tick: sec_units 0->9 with borrow, else -1; sec_tens on borrow 0->5 with borrow, else -1; min_units on borrow 0->9 with borrow, else -1; min_tens on borrow -1.
REQ-019 Entered values sec_tens 6..9 are kept and decrement normally (e.g. 99:99 -> 99:98; 99:00 -> 98:59).
REQ-020 Tick that yields 00:00: -> DONE; digits show 0000; running 0 from that edge.
REQ-021 DONE: done=1 for exactly that one cycle; unconditionally -> IDLE next edge; start/stop/digit_valid in DONE ignored.
REQ-022 RUN+stop: -> PAUSE; digits and prescaler held; a coincident tick is dropped (no decrement).
REQ-023 PAUSE+start: -> RUN, prescaler resumes from held count (not reset).
REQ-024 PAUSE+stop: digits -> 0, -> IDLE.
REQ-025 start and stop same cycle: stop action only.
REQ-026 running==1 iff state==RUN; done==1 iff state==DONE.

Reset
REQ-027 clear==0 at a clk edge: state IDLE, all digits 0, prescaler 0, running 0, done 0, regardless of other inputs or current state (including mid-RUN).
REQ-028 Outputs are undefined only before the first clk edge with clear==0; no asynchronous path from clear.

Verification (TICK_DIV=4)
REQ-029 clear=0 for 2 cycles in mid-RUN with start=1 and digit_valid=1 -> all digits 0, running 0, done 0; remains IDLE after clear=1.
REQ-030 Enter 0,1,0,5 then start -> display 01:05, running=1 next edge; 4 cycles later 01:04; digit_valid with 7 during RUN -> no change.
REQ-031 Load 0100, start -> first tick gives 00:59; load 1000 -> first tick gives 09:59.
REQ-032 Load 0002, start -> 8 cycles later 00:00 with done=1 one cycle, running 0; next cycle state IDLE, done 0.
REQ-033 Load 0010, start, stop after 2 cycles -> value 00:10 held for 20 cycles; start -> 00:09 exactly 2 cycles later; stop, stop -> 00:00, IDLE.
REQ-034 Start with 0000 -> running stays 0; digit 0xA -> ignored; start+stop same cycle with 0005 loaded -> digits cleared, running 0.
